// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and byte-merge helper for the write-buffered data memory.
package dmem_pkg;
    localparam int DMEM_WORD_BYTES = 4;
    localparam int DMEM_WIDX_W = 30;

    typedef struct packed {
        logic [DMEM_WIDX_W-1:0] widx;
        logic [3:0]             strb;
        logic [31:0]            data;
    } wbuf_entry_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < DMEM_WORD_BYTES; b++)
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/dmem_wbuf_fifo.sv
// dmem_wbuf_fifo: store write buffer; exports all entries oldest-first with a valid mask
// so the top level can forward buffered bytes into reads.
module dmem_wbuf_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic        i_pop,
    input  wbuf_entry_t i_entry,
    output wbuf_entry_t o_head,
    output wbuf_entry_t o_ord [DEPTH],
    output logic [DEPTH-1:0] o_vld,
    output logic [CW-1:0]    o_count,
    output logic        o_full,
    output logic        o_empty
);
    wbuf_entry_t    r_mem [DEPTH];
    logic [PW-1:0]  r_wptr, r_rptr;
    logic [CW-1:0]  r_count;
    logic           w_push_ok, w_pop_ok;

    assign o_count   = r_count;
    assign o_full    = r_count == CW'(DEPTH);
    assign o_empty   = r_count == '0;
    assign w_pop_ok  = i_pop & ~o_empty;
    // A push while full only fits when the head leaves at the same edge.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_head    = r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    always_ff @(posedge clk)
        if (w_push_ok) r_mem[r_wptr] <= i_entry;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_ord[i] = r_mem[r_rptr + PW'(i)];
            o_vld[i] = CW'(i) < r_count;
        end
    end
endmodule

// File: rtl/data_mem_wbuf.sv
// data_mem_wbuf: word array fed by a store write buffer, registered reads.
// Define DMEM_FWD_EN to merge buffered stores into read data (coherent reads).
module data_mem_wbuf
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WBUF_DEPTH = 4,
    localparam int CW = $clog2(WBUF_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data_read,
    input  logic [31:0]   data_addr,
    input  logic [3:0]    data_write,
    input  logic [31:0]   data_in,
    output logic [31:0]   data_out,
    output logic [CW-1:0] wbuf_count,
    output logic          wbuf_full,
    output logic          wbuf_empty,
    output logic          ovf_err
);
    logic [31:0]           r_mem [2**ADDR_W];
    logic                  w_in_range, w_push, w_pop, w_unused;
    logic [31:0]           w_rd;
    wbuf_entry_t           w_entry, w_head;
    wbuf_entry_t           w_ord [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0] w_vld;

    assign w_in_range = ~|data_addr[31:ADDR_W+2];
    assign w_push     = |data_write & w_in_range;
    assign w_pop      = ~wbuf_empty;
    assign w_entry    = '{widx: data_addr[31:2], strb: data_write, data: data_in};

    dmem_wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_entry (w_entry),
        .o_head  (w_head),
        .o_ord   (w_ord),
        .o_vld   (w_vld),
        .o_count (wbuf_count),
        .o_full  (wbuf_full),
        .o_empty (wbuf_empty)
    );

    // Array is intentionally not reset; retirement writes only the strobed bytes.
    always_ff @(posedge clk)
        if (w_pop)
            for (int b = 0; b < DMEM_WORD_BYTES; b++)
                if (w_head.strb[b]) r_mem[w_head.widx[ADDR_W-1:0]][8*b +: 8] <= w_head.data[8*b +: 8];

    always_comb begin
        w_rd = r_mem[data_addr[ADDR_W+1:2]];
`ifdef DMEM_FWD_EN
        for (int i = 0; i < WBUF_DEPTH; i++)
            if (w_vld[i] && w_ord[i].widx == data_addr[31:2])
                w_rd = byte_merge(w_rd, w_ord[i].data, w_ord[i].strb);
`endif
    end

    always_comb begin
        w_unused = ^{data_addr[1:0], w_head.widx[DMEM_WIDX_W-1:ADDR_W]};
`ifndef DMEM_FWD_EN
        w_unused = w_unused ^ (^w_vld);
        for (int i = 0; i < WBUF_DEPTH; i++) w_unused = w_unused ^ (^w_ord[i]);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            ovf_err  <= 1'b0;
        end else begin
            if (data_read) data_out <= w_in_range ? w_rd : '0;
            // Unreachable while the head retires every cycle; kept for a future retire-stall.
            if (w_push & wbuf_full & ~w_pop) ovf_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_data_mem_wbuf.sv
// tb_data_mem_wbuf: scoreboard bench; a behavioural model predicts read data and occupancy.
module tb_data_mem_wbuf;
    localparam int DEPTH = 4;

    typedef struct {
        int unsigned idx;
        logic [3:0]  s;
        logic [31:0] d;
    } st_t;

    logic        clk = 0, rst = 0, data_read = 0;
    logic [31:0] data_addr = 0, data_in = 0;
    logic [3:0]  data_write = 0;
    logic [31:0] data_out;
    logic [2:0]  wbuf_count;
    logic        wbuf_full, wbuf_empty, ovf_err;

    logic [31:0] m_arr [1024];
    st_t         pend [$];
    logic [31:0] exp_q [$];
    logic [31:0] e, keep;
    int          n_chk = 0, n_pass = 0;

    data_mem_wbuf #(.ADDR_W(10), .WBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_read(data_read), .data_addr(data_addr),
        .data_write(data_write), .data_in(data_in), .data_out(data_out),
        .wbuf_count(wbuf_count), .wbuf_full(wbuf_full), .wbuf_empty(wbuf_empty), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        if (a[31:12] != 0) return 32'h0;
        w = m_arr[a[11:2]];
`ifdef DMEM_FWD_EN
        foreach (pend[k])
            if (pend[k].idx == a[11:2])
                for (int b = 0; b < 4; b++) if (pend[k].s[b]) w[8*b +: 8] = pend[k].d[8*b +: 8];
`endif
        return w;
    endfunction

    task automatic step(input logic rd, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        st_t h;
        data_read = rd; data_addr = a; data_write = s; data_in = d;
        if (rd) exp_q.push_back(model_read(a));
        @(posedge clk);
        if (pend.size() > 0) begin
            h = pend.pop_front();
            for (int b = 0; b < 4; b++) if (h.s[b]) m_arr[h.idx][8*b +: 8] = h.d[8*b +: 8];
        end
        if (s != 0 && a[31:12] == 0) pend.push_back('{idx: a[11:2], s: s, d: d});
        #1;
        data_read = 0; data_write = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        pend.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (data_out !== 32'h0) $display("FAIL rst_data_out got=%h exp=0", data_out); else n_pass++;
        n_chk++; if (wbuf_count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", wbuf_count); else n_pass++;
        n_chk++; if (wbuf_empty !== 1'b1 || wbuf_full !== 1'b0) $display("FAIL rst_flags empty=%b full=%b exp 1/0", wbuf_empty, wbuf_full); else n_pass++;
        n_chk++; if (ovf_err !== 1'b0) $display("FAIL rst_ovf got=%b exp=0", ovf_err); else n_pass++;
        @(negedge clk); rst = 0; @(posedge clk); #1;
        for (int i = 0; i < 16; i++)
            step(0, 32'(i * 4), 4'hF, i == 0 ? 32'h0 : i == 4 ? 32'h01020304 : i == 8 ? 32'h11223344 : 32'hA5000000 | 32'(i));
        repeat (3) step(0, 0, 0, 0);
        step(1, 32'h0, 0, 0); e = exp_q.pop_front();
        n_chk++; if (data_out !== 32'h0 || e !== 32'h0) $display("FAIL rd_addr0 got=%h exp=0", data_out); else n_pass++;
        n_chk++; if (wbuf_empty !== 1'b1) $display("FAIL drained_empty got=%b exp=1", wbuf_empty); else n_pass++;
    endtask

    task automatic test_forward();
        step(0, 32'h10, 4'hF, 32'hDEADBEEF);
        n_chk++; if (wbuf_count !== 3'd1) $display("FAIL fwd_count got=%0d exp=1", wbuf_count); else n_pass++;
        step(1, 32'h10, 0, 0); e = exp_q.pop_front();
`ifdef DMEM_FWD_EN
        n_chk++; if (data_out !== 32'hDEADBEEF) $display("FAIL fwd_read got=%h exp=deadbeef", data_out); else n_pass++;
`else
        n_chk++; if (data_out !== 32'h01020304) $display("FAIL raw_read got=%h exp=01020304", data_out); else n_pass++;
`endif
        n_chk++; if (data_out !== e) $display("FAIL fwd_model got=%h exp=%h", data_out, e); else n_pass++;
        step(1, 32'h10, 0, 0); e = exp_q.pop_front();
        n_chk++; if (data_out !== 32'hDEADBEEF) $display("FAIL fwd_retired got=%h exp=deadbeef", data_out); else n_pass++;
    endtask

    task automatic test_merge();
        step(0, 32'h20, 4'b0010, 32'h0000AA00);
        step(1, 32'h20, 4'b0001, 32'h000000BB); e = exp_q.pop_front();
        n_chk++; if (data_out !== e) $display("FAIL merge_rbw got=%h exp=%h", data_out, e); else n_pass++;
        step(1, 32'h20, 0, 0); e = exp_q.pop_front();
        n_chk++; if (data_out !== e) $display("FAIL merge_during got=%h exp=%h", data_out, e); else n_pass++;
`ifdef DMEM_FWD_EN
        n_chk++; if (data_out !== 32'h1122AABB) $display("FAIL merge_fwd got=%h exp=1122aabb", data_out); else n_pass++;
`endif
        step(1, 32'h20, 0, 0); e = exp_q.pop_front();
        n_chk++; if (data_out !== 32'h1122AABB) $display("FAIL merge_after got=%h exp=1122aabb", data_out); else n_pass++;
        step(0, 0, 0, 0);
        n_chk++; if (data_out !== 32'h1122AABB) $display("FAIL read_hold got=%h exp=1122aabb", data_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            step(0, 32'h80 + 32'(i * 4), 4'hF, 32'hC0DE0000 + 32'(i * 17));
            n_chk++; if (wbuf_count > 3'd1 || wbuf_count !== 3'(pend.size())) $display("FAIL b2b_count[%0d] got=%0d exp=%0d", i, wbuf_count, pend.size()); else n_pass++;
            n_chk++; if (ovf_err !== 1'b0) $display("FAIL b2b_ovf[%0d] got=%b exp=0", i, ovf_err); else n_pass++;
        end
        step(0, 0, 0, 0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            step(1, 32'h80 + 32'(i * 4), 0, 0); e = exp_q.pop_front();
            n_chk++; if (data_out !== 32'hC0DE0000 + 32'(i * 17)) $display("FAIL b2b_read[%0d] got=%h exp=%h", i, data_out, 32'hC0DE0000 + 32'(i * 17)); else n_pass++;
        end
    endtask

    task automatic test_range();
        step(0, 32'h0001_0000, 4'hF, 32'h12345678);
        n_chk++; if (wbuf_empty !== 1'b1) $display("FAIL range_empty got=%b exp=1", wbuf_empty); else n_pass++;
        step(1, 32'h0001_0000, 0, 0); e = exp_q.pop_front();
        n_chk++; if (data_out !== 32'h0) $display("FAIL range_read got=%h exp=0", data_out); else n_pass++;
        step(1, 32'h0, 0, 0); e = exp_q.pop_front();
        n_chk++; if (data_out !== 32'h0) $display("FAIL range_alias got=%h exp=0", data_out); else n_pass++;
    endtask

    task automatic test_reset_flush();
        step(1, 32'h3C, 0, 0); e = exp_q.pop_front();
        keep = m_arr[15];
        n_chk++; if (data_out !== keep) $display("FAIL flush_pre got=%h exp=%h", data_out, keep); else n_pass++;
        step(0, 32'h3C, 4'hF, 32'hFFFF0000);
        #2 do_reset();
        n_chk++; if (wbuf_empty !== 1'b1) $display("FAIL flush_empty got=%b exp=1", wbuf_empty); else n_pass++;
        n_chk++; if (data_out !== 32'h0) $display("FAIL flush_data_out got=%h exp=0", data_out); else n_pass++;
        @(negedge clk); rst = 0; @(posedge clk); #1;
        step(1, 32'h3C, 0, 0); e = exp_q.pop_front();
        n_chk++; if (data_out !== keep) $display("FAIL flush_array got=%h exp=%h", data_out, keep); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_forward();
        test_merge();
        test_back_to_back();
        test_range();
        test_reset_flush();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
